// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity-mode constants and
// the frame-length helper that the TX block uses as well.
package uart_pkg;

  typedef enum logic [6:0] {
    ST_IDLE      = 7'b000_0001,
    ST_START     = 7'b000_0010,
    ST_DATA      = 7'b000_0100,
    ST_PARITY    = 7'b000_1000,
    ST_STOP      = 7'b001_0000,
    ST_DONE      = 7'b010_0000,
    ST_WAIT_HIGH = 7'b100_0000
  } uart_rx_state_t;

  localparam logic PARITY_MODE_EVEN = 1'b0;
  localparam logic PARITY_MODE_ODD  = 1'b1;

  function automatic int unsigned uart_frame_ticks(input int unsigned data_w,
                                                   input int unsigned parity_en,
                                                   input int unsigned stop_bits,
                                                   input int unsigned ovs);
    return (1 + data_w + parity_en + stop_bits) * ovs;
  endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Line-side and word-side signals of the configurable UART receiver.
interface uart_rx_cfg_if #(
  parameter int DATA_W = 8
);
  logic              tick_i;
  logic              rxd_i;
  logic              vd_o;
  logic [DATA_W-1:0] data_o;
  logic              parity_err_o;
  logic              frame_err_o;
  logic              break_o;
  logic              busy_o;

  modport master (
    output tick_i, rxd_i,
    input  vd_o, data_o, parity_err_o, frame_err_o, break_o, busy_o
  );

  modport slave (
    input  tick_i, rxd_i,
    output vd_o, data_o, parity_err_o, frame_err_o, break_o, busy_o
  );
endinterface

// File: rtl/uart_rx_filter.sv
// Three-sample majority voter on the raw RX line; single-clock glitches never
// reach the output. Idles high out of reset so no spurious start is seen.
module uart_rx_filter (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rxd_i,
  output logic rxd_sync_o
);

  logic [2:0] rxd;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rxd        <= 3'b111;
      rxd_sync_o <= 1'b1;
    end else begin
      rxd        <= {rxd[1:0], rxd_i};
      rxd_sync_o <= (rxd[0] & rxd[1]) | (rxd[1] & rxd[2]) | (rxd[0] & rxd[2]);
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receive PHY: majority-filtered line, per-bit vote counting
// over an OVS-tick window, parity/framing/break reporting.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int OVS        = 16,
  parameter int LEVEL      = OVS / 2,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  uart_rx_cfg_if.slave   bus
);

  localparam int   TW       = (OVS > 1) ? $clog2(OVS) : 1;
  localparam int   OW       = $clog2(OVS + 1);
  localparam int   BW       = $clog2(DATA_W + 1);
  localparam logic PAR_MODE = (PARITY_ODD != 0) ? PARITY_MODE_ODD : PARITY_MODE_EVEN;

  uart_rx_state_t    state, state_nxt;
  logic              rxd_sync;
  logic [TW-1:0]     tick_cnt, tick_cnt_nxt;
  logic [OW-1:0]     ones, ones_nxt, ones_sum;
  logic [BW-1:0]     bit_cnt, bit_cnt_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt;
  logic              par_acc, par_acc_nxt;
  logic              par_err, par_err_nxt;
  logic              frm_err, frm_err_nxt;
  logic              any_one, any_one_nxt;
  logic              last_stop, last_stop_nxt;
  logic              win_end, bit_val, in_window;
  logic              vd_q, perr_q, ferr_q, brk_q;
  logic [DATA_W-1:0] data_q;

  uart_rx_filter u_filter (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rxd_i      (bus.rxd_i),
    .rxd_sync_o (rxd_sync)
  );

  // The vote includes the sample taken on the window's closing tick.
  assign ones_sum  = ones + OW'(rxd_sync);
  assign bit_val   = (ones_sum >= OW'(LEVEL));
  assign win_end   = bus.tick_i && (tick_cnt == TW'(OVS - 1));
  assign in_window = (state == ST_START) || (state == ST_DATA) ||
                     (state == ST_PARITY) || (state == ST_STOP);

  always_comb begin
    state_nxt     = state;
    tick_cnt_nxt  = tick_cnt;
    ones_nxt      = ones;
    bit_cnt_nxt   = bit_cnt;
    shreg_nxt     = shreg;
    par_acc_nxt   = par_acc;
    par_err_nxt   = par_err;
    frm_err_nxt   = frm_err;
    any_one_nxt   = any_one;
    last_stop_nxt = last_stop;

    if (in_window && bus.tick_i) begin
      if (win_end) begin
        tick_cnt_nxt = '0;
        ones_nxt     = '0;
      end else begin
        tick_cnt_nxt = tick_cnt + TW'(1);
        ones_nxt     = ones_sum;
      end
    end

    case (state)
      ST_IDLE: begin
        // The falling-edge sample is sample 1 of the start window and is low.
        if (bus.tick_i && !rxd_sync) begin
          state_nxt    = ST_START;
          tick_cnt_nxt = TW'(1);
          ones_nxt     = '0;
          bit_cnt_nxt  = '0;
          par_acc_nxt  = 1'b0;
          par_err_nxt  = 1'b0;
          frm_err_nxt  = 1'b0;
          any_one_nxt  = 1'b0;
        end
      end
      ST_START: begin
        if (win_end) state_nxt = bit_val ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (win_end) begin
          shreg_nxt   = {bit_val, shreg[DATA_W-1:1]};
          par_acc_nxt = par_acc ^ bit_val;
          any_one_nxt = any_one | bit_val;
          if (bit_cnt == BW'(DATA_W - 1)) begin
            bit_cnt_nxt = '0;
            state_nxt   = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_nxt = bit_cnt + BW'(1);
          end
        end
      end
      ST_PARITY: begin
        if (win_end) begin
          par_err_nxt = ((par_acc ^ bit_val) != PAR_MODE);
          any_one_nxt = any_one | bit_val;
          state_nxt   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (win_end) begin
          frm_err_nxt   = frm_err | ~bit_val;
          last_stop_nxt = bit_val;
          // Only the first stop bit takes part in break detection.
          if (bit_cnt == '0) any_one_nxt = any_one | bit_val;
          if (bit_cnt == BW'(STOP_BITS - 1)) begin
            bit_cnt_nxt = '0;
            state_nxt   = ST_DONE;
          end else begin
            bit_cnt_nxt = bit_cnt + BW'(1);
          end
        end
      end
      ST_DONE: begin
        state_nxt = last_stop ? ST_IDLE : ST_WAIT_HIGH;
      end
      ST_WAIT_HIGH: begin
        if (bus.tick_i && rxd_sync) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      tick_cnt  <= '0;
      ones      <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_acc   <= 1'b0;
      par_err   <= 1'b0;
      frm_err   <= 1'b0;
      any_one   <= 1'b0;
      last_stop <= 1'b0;
    end else begin
      state     <= state_nxt;
      tick_cnt  <= tick_cnt_nxt;
      ones      <= ones_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shreg     <= shreg_nxt;
      par_acc   <= par_acc_nxt;
      par_err   <= par_err_nxt;
      frm_err   <= frm_err_nxt;
      any_one   <= any_one_nxt;
      last_stop <= last_stop_nxt;
    end
  end

  // Word and flags are captured on entry to ST_DONE so they are valid with vd_o.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vd_q   <= 1'b0;
      data_q <= '0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      brk_q  <= 1'b0;
    end else begin
      vd_q <= (state_nxt == ST_DONE);
      if (state_nxt == ST_DONE) begin
        data_q <= shreg;
        perr_q <= par_err_nxt;
        ferr_q <= frm_err_nxt;
        brk_q  <= ~any_one_nxt;
      end
    end
  end

  assign bus.vd_o         = vd_q;
  assign bus.data_o       = data_q;
  assign bus.parity_err_o = perr_q;
  assign bus.frame_err_o  = ferr_q;
  assign bus.break_o      = brk_q;
  assign bus.busy_o       = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: three configurations (8N1, 7O1, 8N2) share
// clock, reset and tick; one line driver is steered to the receiver under test.
module tb_uart_rx_cfg;
  import uart_pkg::*;

  localparam int OVS = 16;

  logic clk;
  logic rst;
  logic tick;
  logic line;
  int   sel;

  int n_cmp = 0;
  int n_err = 0;

  uart_rx_cfg_if #(.DATA_W(8)) if_a ();
  uart_rx_cfg_if #(.DATA_W(7)) if_b ();
  uart_rx_cfg_if #(.DATA_W(8)) if_c ();

  assign if_a.tick_i = tick;
  assign if_b.tick_i = tick;
  assign if_c.tick_i = tick;
  assign if_a.rxd_i  = (sel == 0) ? line : 1'b1;
  assign if_b.rxd_i  = (sel == 1) ? line : 1'b1;
  assign if_c.rxd_i  = (sel == 2) ? line : 1'b1;

  uart_rx_cfg #(.DATA_W(8), .OVS(OVS)) dut_a (
    .clk_i (clk), .rst_i (rst), .bus (if_a.slave)
  );
  uart_rx_cfg #(.DATA_W(7), .OVS(OVS), .PARITY_EN(1), .PARITY_ODD(1)) dut_b (
    .clk_i (clk), .rst_i (rst), .bus (if_b.slave)
  );
  uart_rx_cfg #(.DATA_W(8), .OVS(OVS), .STOP_BITS(2)) dut_c (
    .clk_i (clk), .rst_i (rst), .bus (if_c.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Per-receiver capture of every vd_o pulse and of busy_o around it.
  int         vcnt[3]     = '{0, 0, 0};
  logic [8:0] dat[3]      = '{9'h0, 9'h0, 9'h0};
  logic       pe[3]       = '{1'b0, 1'b0, 1'b0};
  logic       fe[3]       = '{1'b0, 1'b0, 1'b0};
  logic       bk[3]       = '{1'b0, 1'b0, 1'b0};
  logic       bz_vd[3]    = '{1'b0, 1'b0, 1'b0};
  logic       bz_after[3] = '{1'b1, 1'b1, 1'b1};
  logic       pvd[3]      = '{1'b0, 1'b0, 1'b0};

  always @(negedge clk) begin
    if (if_a.vd_o) begin
      vcnt[0]++; dat[0] = {1'b0, if_a.data_o}; pe[0] = if_a.parity_err_o;
      fe[0] = if_a.frame_err_o; bk[0] = if_a.break_o; bz_vd[0] = if_a.busy_o;
    end
    if (pvd[0]) bz_after[0] = if_a.busy_o;
    pvd[0] = if_a.vd_o;
    if (if_b.vd_o) begin
      vcnt[1]++; dat[1] = {2'b0, if_b.data_o}; pe[1] = if_b.parity_err_o;
      fe[1] = if_b.frame_err_o; bk[1] = if_b.break_o; bz_vd[1] = if_b.busy_o;
    end
    if (pvd[1]) bz_after[1] = if_b.busy_o;
    pvd[1] = if_b.vd_o;
    if (if_c.vd_o) begin
      vcnt[2]++; dat[2] = {1'b0, if_c.data_o}; pe[2] = if_c.parity_err_o;
      fe[2] = if_c.frame_err_o; bk[2] = if_c.break_o; bz_vd[2] = if_c.busy_o;
    end
    if (pvd[2]) bz_after[2] = if_c.busy_o;
    pvd[2] = if_c.vd_o;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One tick period of four clocks; the optional glitch inverts the line for
  // the single clock that carries the tick.
  task automatic per(input logic lvl, input bit glitch);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      line = (glitch && c == 3) ? ~lvl : lvl;
      tick = (c == 3);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) per(1'b1, 1'b0);
  endtask

  task automatic bit_time(input logic lvl, input bit glitch, input int inv_lo, input int inv_hi);
    for (int t = 0; t < OVS; t++)
      per((t >= inv_lo && t <= inv_hi) ? ~lvl : lvl, glitch);
  endtask

  task automatic send_frame(input int dw, input logic [8:0] d, input bit pen,
                            input logic pbit, input int nstop, input logic [1:0] stops,
                            input bit glitch, input int inv_bit);
    bit_time(1'b0, glitch, -1, -1);
    for (int i = 0; i < dw; i++)
      bit_time(d[i], glitch, (i == inv_bit) ? 4 : -1, (i == inv_bit) ? 10 : -1);
    if (pen) bit_time(pbit, glitch, -1, -1);
    for (int s = 0; s < nstop; s++) bit_time(stops[s], glitch, -1, -1);
  endtask

  initial begin
    rst  = 1'b1;
    tick = 1'b0;
    line = 1'b1;
    sel  = 0;
    repeat (3) @(negedge clk);
    chk("rst_vd",    32'(if_a.vd_o), 32'd0);
    chk("rst_data",  32'(if_a.data_o), 32'h0);
    chk("rst_busy",  32'(if_a.busy_o), 32'd0);
    chk("rst_flags", {29'd0, if_a.parity_err_o, if_a.frame_err_o, if_a.break_o}, 32'd0);
    chk("rst_busy_b", 32'(if_b.busy_o), 32'd0);
    rst = 1'b0;
    idle(4);

    // Clean 8N1 frame.
    send_frame(8, 9'h0A5, 1'b0, 1'b0, 1, 2'b11, 1'b0, -1);
    idle(4);
    chk("a5_cnt",   32'(vcnt[0]), 32'd1);
    chk("a5_data",  32'(dat[0]), 32'h0A5);
    chk("a5_flags", {29'd0, pe[0], fe[0], bk[0]}, 32'd0);
    chk("a5_busy_at_vd", 32'(bz_vd[0]), 32'd1);
    chk("a5_busy_after", 32'(bz_after[0]), 32'd0);

    // Glitch in every tick period plus 7 inverted ticks in bit 2.
    send_frame(8, 9'h03C, 1'b0, 1'b0, 1, 2'b11, 1'b1, 2);
    idle(4);
    chk("noise_cnt",   32'(vcnt[0]), 32'd2);
    chk("noise_data",  32'(dat[0]), 32'h03C);
    chk("noise_flags", {29'd0, pe[0], fe[0], bk[0]}, 32'd0);

    // Six-tick low pulse: start window votes high, receiver gives up.
    for (int k = 0; k < 6; k++) per(1'b0, 1'b0);
    idle(1);
    chk("fs_busy_in", 32'(if_a.busy_o), 32'd1);
    idle(10);
    chk("fs_busy_out", 32'(if_a.busy_o), 32'd0);
    chk("fs_cnt", 32'(vcnt[0]), 32'd2);

    // 7O1: 0x41 has two ones, so the correct odd parity bit is 1.
    sel = 1;
    idle(2);
    send_frame(7, 9'h041, 1'b1, 1'b0, 1, 2'b11, 1'b0, -1);
    idle(4);
    chk("par_bad_cnt",  32'(vcnt[1]), 32'd1);
    chk("par_bad_data", 32'(dat[1]), 32'h041);
    chk("par_bad_pe",   32'(pe[1]), 32'd1);
    chk("par_bad_fe",   32'(fe[1]), 32'd0);
    send_frame(7, 9'h041, 1'b1, 1'b1, 1, 2'b11, 1'b0, -1);
    idle(4);
    chk("par_ok_cnt", 32'(vcnt[1]), 32'd2);
    chk("par_ok_pe",  32'(pe[1]), 32'd0);
    send_frame(7, 9'h02A, 1'b1, 1'b0, 1, 2'b11, 1'b0, -1);
    idle(4);
    chk("par_2a_data", 32'(dat[1]), 32'h02A);
    chk("par_2a_pe",   32'(pe[1]), 32'd0);

    // 8N2: second stop bit low.
    sel = 2;
    idle(2);
    send_frame(8, 9'h096, 1'b0, 1'b0, 2, 2'b01, 1'b0, -1);
    idle(4);
    chk("stop2_cnt",  32'(vcnt[2]), 32'd1);
    chk("stop2_data", 32'(dat[2]), 32'h096);
    chk("stop2_fe",   32'(fe[2]), 32'd1);
    chk("stop2_bk",   32'(bk[2]), 32'd0);
    send_frame(8, 9'h069, 1'b0, 1'b0, 2, 2'b11, 1'b0, -1);
    idle(4);
    chk("stop_ok_cnt", 32'(vcnt[2]), 32'd2);
    chk("stop_ok_fe",  32'(fe[2]), 32'd0);
    chk("stop_ok_data", 32'(dat[2]), 32'h069);

    // Break: 20 bit times low on the 8N1 receiver.
    sel = 0;
    idle(2);
    for (int k = 0; k < 20 * OVS; k++) per(1'b0, 1'b0);
    idle(1);
    chk("brk_cnt",  32'(vcnt[0]), 32'd3);
    chk("brk_bk",   32'(bk[0]), 32'd1);
    chk("brk_fe",   32'(fe[0]), 32'd1);
    chk("brk_data", 32'(dat[0]), 32'h0);
    idle(3);
    chk("brk_released", 32'(if_a.busy_o), 32'd0);
    send_frame(8, 9'h0C3, 1'b0, 1'b0, 1, 2'b11, 1'b0, -1);
    idle(4);
    chk("post_brk_cnt",  32'(vcnt[0]), 32'd4);
    chk("post_brk_data", 32'(dat[0]), 32'h0C3);
    chk("post_brk_bk",   32'(bk[0]), 32'd0);

    // Reset in the middle of data bit 4 of 0x5A.
    bit_time(1'b0, 1'b0, -1, -1);
    for (int i = 0; i < 4; i++) bit_time(((8'h5A >> i) & 8'h1) != 0, 1'b0, -1, -1);
    for (int k = 0; k < 8; k++) per(1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_data", 32'(if_a.data_o), 32'h0);
    chk("mid_rst_busy", 32'(if_a.busy_o), 32'd0);
    chk("mid_rst_vd",   32'(if_a.vd_o), 32'd0);
    per(1'b1, 1'b0);
    per(1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    idle(OVS);
    chk("mid_rst_cnt", 32'(vcnt[0]), 32'd4);
    send_frame(8, 9'h05A, 1'b0, 1'b0, 1, 2'b11, 1'b0, -1);
    idle(4);
    chk("after_rst_cnt",   32'(vcnt[0]), 32'd5);
    chk("after_rst_data",  32'(dat[0]), 32'h05A);
    chk("after_rst_flags", {29'd0, pe[0], fe[0], bk[0]}, 32'd0);
    chk("other_rx_quiet",  32'(vcnt[1] + vcnt[2]), 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
